// File: rtl/mac_frame_unpacker.sv
// Word-to-byte unpacker: holds one Data Link Layer word and streams its bytes
// LSB-first, with single-cycle latency and bubble-free back-to-back words.
module mac_frame_unpacker #(
   parameter  int MAC_FRAME_WIDTH = 32,
   localparam int NB              = MAC_FRAME_WIDTH / 8,
   localparam int BW              = $clog2(NB) + 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [MAC_FRAME_WIDTH-1:0] mac_data_frame_i,
   input  logic                       mac_data_frame_valid_i,
   input  logic                       mac_data_frame_last_i,
   input  logic [BW-1:0]              mac_data_frame_bytes_i,
   output logic                       mac_data_frame_ready_o,
   output logic [7:0]                 data_byte_o,
   output logic                       data_byte_valid_o,
   output logic                       data_byte_last_o,
   input  logic                       data_byte_ready_i,
   output logic [15:0]                pkt_count_o,
   output logic                       len_err_o
);

   typedef enum logic {
      EMPTY,
      DRAIN
   } state_t;

   localparam logic [BW-1:0] NB_W = BW'(NB);

   state_t                     state_q;
   logic [MAC_FRAME_WIDTH-1:0] word_q;
   logic [BW-1:0]              idx_q;
   logic [BW-1:0]              lim_q;
   logic                       last_q;

   logic          at_lim;
   logic          byte_hs;
   logic          word_acc;
   logic          bytes_ok;
   logic [BW-1:0] lim_next;

   assign at_lim   = (idx_q == lim_q - BW'(1));
   assign byte_hs  = data_byte_valid_o & data_byte_ready_i;
   assign word_acc = mac_data_frame_valid_i & mac_data_frame_ready_o;
   assign bytes_ok = (mac_data_frame_bytes_i != '0) && (mac_data_frame_bytes_i <= NB_W);

   // Refill is allowed in the very cycle the final byte leaves, so words stream without a gap.
   assign mac_data_frame_ready_o = (state_q == EMPTY) | (byte_hs & at_lim);

   assign data_byte_valid_o = (state_q == DRAIN);
   assign data_byte_last_o  = data_byte_valid_o & last_q & at_lim;
   assign data_byte_o       = word_q[{idx_q, 3'b000} +: 8];

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      lim_next = NB_W;
      if (mac_data_frame_last_i && bytes_ok) begin
         lim_next = mac_data_frame_bytes_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; word_q is reset too so the
   // byte output reads zero while reset is held.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= EMPTY;
         word_q      <= '0;
         idx_q       <= '0;
         lim_q       <= NB_W;
         last_q      <= 1'b0;
         pkt_count_o <= '0;
         len_err_o   <= 1'b0;
      end else begin
         if (word_acc) begin
            state_q <= DRAIN;
            word_q  <= mac_data_frame_i;
            idx_q   <= '0;
            lim_q   <= lim_next;
            last_q  <= mac_data_frame_last_i;
            if (mac_data_frame_last_i && !bytes_ok) begin
               len_err_o <= 1'b1;
            end
         end else if (byte_hs) begin
            if (at_lim) begin
               state_q <= EMPTY;
            end else begin
               idx_q <= idx_q + BW'(1);
            end
         end

         if (data_byte_last_o && data_byte_ready_i) begin
            pkt_count_o <= pkt_count_o + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mac_frame_unpacker.sv
// Self-checking bench for mac_frame_unpacker: directed and random words checked
// against a byte-queue reference model of the packet stream.
module tb_mac_frame_unpacker;

   localparam int W  = 32;
   localparam int NB = W / 8;
   localparam int BW = $clog2(NB) + 1;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [W-1:0]  mac_data_frame_i = '0;
   logic          mac_data_frame_valid_i = 1'b0;
   logic          mac_data_frame_last_i = 1'b0;
   logic [BW-1:0] mac_data_frame_bytes_i = '0;
   logic          mac_data_frame_ready_o;
   logic [7:0]    data_byte_o;
   logic          data_byte_valid_o;
   logic          data_byte_last_o;
   logic          data_byte_ready_i = 1'b0;
   logic [15:0]   pkt_count_o;
   logic          len_err_o;

   mac_frame_unpacker #(.MAC_FRAME_WIDTH(W)) dut (
      .clk_i                  (clk_i),
      .rst_i                  (rst_i),
      .mac_data_frame_i       (mac_data_frame_i),
      .mac_data_frame_valid_i (mac_data_frame_valid_i),
      .mac_data_frame_last_i  (mac_data_frame_last_i),
      .mac_data_frame_bytes_i (mac_data_frame_bytes_i),
      .mac_data_frame_ready_o (mac_data_frame_ready_o),
      .data_byte_o            (data_byte_o),
      .data_byte_valid_o      (data_byte_valid_o),
      .data_byte_last_o       (data_byte_last_o),
      .data_byte_ready_i      (data_byte_ready_i),
      .pkt_count_o            (pkt_count_o),
      .len_err_o              (len_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0] b;
      logic       l;
   } exp_byte_t;

   exp_byte_t   exp_q[$];
   int          checks   = 0;
   int          errors   = 0;
   int          hs_count = 0;
   logic [15:0] exp_pkt  = '0;
   logic        exp_err  = 1'b0;
   int          rdy_mode = 0;   // 0: always ready, 1: toggling, 2: random

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(posedge clk_i) begin
      #1;
      case (rdy_mode)
         0:       data_byte_ready_i = 1'b1;
         1:       data_byte_ready_i = ~data_byte_ready_i;
         default: data_byte_ready_i = 1'($urandom_range(0, 1));
      endcase
   end

   // Byte-stream monitor: the output must present exactly the model's next byte whenever
   // bytes are pending, and be idle otherwise.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         check("valid_vs_model", 32'(data_byte_valid_o), 32'(exp_q.size() != 0));
         if (data_byte_valid_o && exp_q.size() != 0) begin
            check("byte", 32'(data_byte_o), 32'(exp_q[0].b));
            check("byte_last", 32'(data_byte_last_o), 32'(exp_q[0].l));
            if (data_byte_ready_i) begin
               if (exp_q[0].l) exp_pkt++;
               exp_q.delete(0);
               hs_count++;
            end
         end
      end
   end

   // Presents one word and holds it until accepted; returns the number of edges waited.
   task automatic send(input logic [W-1:0] d, input logic l, input logic [BW-1:0] n,
                       output int waited);
      logic acc;
      int   nb;
      mac_data_frame_i       = d;
      mac_data_frame_last_i  = l;
      mac_data_frame_bytes_i = n;
      mac_data_frame_valid_i = 1'b1;
      waited = 0;
      acc    = 1'b0;
      while (!acc && waited < 100) begin
         @(negedge clk_i);
         acc = mac_data_frame_ready_o;
         @(posedge clk_i);
         #1;
         waited++;
      end
      mac_data_frame_valid_i = 1'b0;
      mac_data_frame_i       = $urandom;
      mac_data_frame_last_i  = 1'($urandom);
      mac_data_frame_bytes_i = BW'($urandom);
      check("accept", 32'(acc), 32'(1));
      if (acc) begin
         nb = (l && n != 0 && int'(n) <= NB) ? int'(n) : NB;
         if (l && (n == 0 || int'(n) > NB)) exp_err = 1'b1;
         for (int i = 0; i < nb; i++) begin
            exp_q.push_back('{b: d[8*i +: 8], l: l && (i == nb - 1)});
         end
         check("latency_valid", 32'(data_byte_valid_o), 32'(1));
         check("latency_byte0", 32'(data_byte_o), 32'(d[7:0]));
      end
   endtask

   task automatic finish_pkt(input string tag);
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
         @(posedge clk_i);
         #1;
      end
      check({tag, "_drain"}, 32'(exp_q.size()), 32'(0));
      check({tag, "_pkt"}, 32'(pkt_count_o), 32'(exp_pkt));
      check({tag, "_len_err"}, 32'(len_err_o), 32'(exp_err));
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      exp_q.delete();
      exp_pkt = '0;
      exp_err = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      int w;
      int base;
      logic [W-1:0] d;

      repeat (3) @(posedge clk_i);
      #1;
      check("rst_valid", 32'(data_byte_valid_o), 32'(0));
      check("rst_last", 32'(data_byte_last_o), 32'(0));
      check("rst_byte", 32'(data_byte_o), 32'(0));
      check("rst_ready", 32'(mac_data_frame_ready_o), 32'(1));
      check("rst_pkt", 32'(pkt_count_o), 32'(0));
      check("rst_len_err", 32'(len_err_o), 32'(0));
      rst_i = 1'b0;

      // Single 4-byte packet.
      rdy_mode = 0;
      @(posedge clk_i);
      #1;
      send(32'h4433_2211, 1'b1, 3'd4, w);
      check("idle_accept_wait", 32'(w), 32'(1));
      finish_pkt("single");
      check("single_pkt_is_1", 32'(pkt_count_o), 32'(1));

      // Back-to-back words: second word accepted in the cycle DD leaves.
      send(32'hDDCC_BBAA, 1'b0, BW'($urandom), w);
      send(32'h0000_0099, 1'b1, 3'd1, w);
      check("b2b_wait", 32'(w), 32'(4));
      finish_pkt("b2b");

      // Toggling downstream ready.
      rdy_mode = 1;
      send($urandom, 1'b0, 3'd0, w);
      send($urandom, 1'b1, 3'd3, w);
      finish_pkt("toggle");

      // Illegal byte counts.
      rdy_mode = 0;
      send($urandom, 1'b1, 3'd0, w);
      finish_pkt("bytes0");
      check("bytes0_err", 32'(len_err_o), 32'(1));
      do_reset();
      send($urandom, 1'b1, 3'd5, w);
      finish_pkt("bytes5");
      check("bytes5_err", 32'(len_err_o), 32'(1));

      // Random words, lengths and downstream back-pressure.
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         send($urandom, ($urandom_range(0, 2) == 0), BW'($urandom_range(0, 7)), w);
      end
      finish_pkt("random");

      // Asynchronous reset mid-packet.
      do_reset();
      rdy_mode = 0;
      base = hs_count;
      d = $urandom;
      send(d, 1'b1, 3'd4, w);
      for (int k = 0; k < 20 && hs_count < base + 2; k++) begin
         @(posedge clk_i);
         #1;
      end
      check("midrst_two_bytes", 32'(hs_count - base), 32'(2));
      #2;
      rst_i = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_valid", 32'(data_byte_valid_o), 32'(0));
      check("midrst_last", 32'(data_byte_last_o), 32'(0));
      check("midrst_byte", 32'(data_byte_o), 32'(0));
      check("midrst_ready", 32'(mac_data_frame_ready_o), 32'(1));
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check("midrst_pkt", 32'(pkt_count_o), 32'(0));
      send(32'h8877_6655, 1'b1, 3'd4, w);
      finish_pkt("after_rst");

      // Counter wrap.
      do_reset();
      for (int i = 0; i < 65535; i++) begin
         send($urandom, 1'b1, 3'd1, w);
      end
      finish_pkt("preload");
      check("preload_ffff", 32'(pkt_count_o), 32'h0000_FFFF);
      send($urandom, 1'b1, 3'd1, w);
      finish_pkt("wrap");
      check("wrap_zero", 32'(pkt_count_o), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
